// File: rtl/axi_grid_xni_w_steer.sv
// AW/W grid steering stage: decodes the destination ID from each AW address,
// remembers it per burst in a small FIFO, tags every W beat of that burst with
// the same destination, and presents both channels through one-deep registers.
module axi_grid_xni_w_steer #(
    parameter int GRID_ID_W = 4,
    parameter int ADDR_W    = 32,
    parameter int DID_LSB   = 28,
    parameter int AW_CHAN_W = 64,
    parameter int W_CHAN_W  = 72,
    parameter int DEPTH     = 4,
    parameter int NI_ID     = 0
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic [ADDR_W-1:0]            awaddr_i,
    input  logic [AW_CHAN_W-1:0]         awchan_i,
    input  logic                         awvalid_i,
    output logic                         awready_o,
    output logic [GRID_ID_W-1:0]         awdid_o,
    output logic [GRID_ID_W-1:0]         awsid_o,
    output logic [AW_CHAN_W-1:0]         awchan_o,
    output logic                         awvalid_o,
    input  logic                         awready_i,
    input  logic [W_CHAN_W-1:0]          wchan_i,
    input  logic                         wlast_i,
    input  logic                         wvalid_i,
    output logic                         wready_o,
    output logic [GRID_ID_W-1:0]         wdid_o,
    output logic [GRID_ID_W-1:0]         wsid_o,
    output logic [W_CHAN_W-1:0]          wchan_o,
    output logic                         wlast_o,
    output logic                         wvalid_o,
    input  logic                         wready_i,
    output logic [$clog2(DEPTH+1)-1:0]   outstanding_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    logic                 aw_slot_free;
    logic                 w_slot_free;
    logic                 aw_fire;
    logic                 w_fire;
    logic                 pop;
    logic [GRID_ID_W-1:0] aw_did;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count_next;
    logic [GRID_ID_W-1:0] did_mem [DEPTH];
    logic                 addr_unused;

    // Only the destination field of the address matters; the rest is folded
    // away so the remaining address bits are visibly intentionally ignored.
    assign addr_unused = ^awaddr_i;
    assign aw_did      = awaddr_i[DID_LSB +: GRID_ID_W];

    // Handshake qualification: AW blocks on a full FIFO, W blocks until a
    // destination has been recorded for its burst.
    assign aw_slot_free = !awvalid_o || awready_i;
    assign w_slot_free  = !wvalid_o || wready_i;
    assign awready_o    = aw_slot_free && (outstanding_o != CNT_W'(DEPTH));
    assign wready_o     = w_slot_free && (outstanding_o != '0);
    assign aw_fire      = awvalid_i && awready_o;
    assign w_fire       = wvalid_i && wready_o;
    assign pop          = w_fire && wlast_i;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Next occupancy: a simultaneous push and pop leaves the count unchanged.
    always_comb begin
        // NOTE: default assignment first so every path drives count_next and no latch is inferred.
        count_next = outstanding_o;
        if (aw_fire && !pop) begin
            count_next = outstanding_o + CNT_W'(1);
        end else if (pop && !aw_fire) begin
            count_next = outstanding_o - CNT_W'(1);
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst_i) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            outstanding_o <= '0;
        end else begin
            if (aw_fire) wr_ptr <= ptr_inc(wr_ptr);
            if (pop)     rd_ptr <= ptr_inc(rd_ptr);
            outstanding_o <= count_next;
        end
    end

    // Destination storage, written on every AW accept.
    always_ff @(posedge clk_i) begin
        // NOTE: storage is not reset; clearing the pointers already makes stale entries unreachable.
        if (aw_fire) did_mem[wr_ptr] <= aw_did;
    end

    // AW output register: load on accept, drop valid once drained downstream.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            awvalid_o <= 1'b0;
            awdid_o   <= '0;
            awsid_o   <= '0;
            awchan_o  <= '0;
        end else if (aw_fire) begin
            awvalid_o <= 1'b1;
            awdid_o   <= aw_did;
            awsid_o   <= GRID_ID_W'(NI_ID);
            awchan_o  <= awchan_i;
        end else if (awready_i) begin
            awvalid_o <= 1'b0;
        end
    end

    // W output register: beat tagged with the destination at the FIFO head.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wvalid_o <= 1'b0;
            wdid_o   <= '0;
            wsid_o   <= '0;
            wchan_o  <= '0;
            wlast_o  <= 1'b0;
        end else if (w_fire) begin
            wvalid_o <= 1'b1;
            wdid_o   <= did_mem[rd_ptr];
            wsid_o   <= GRID_ID_W'(NI_ID);
            wchan_o  <= wchan_i;
            wlast_o  <= wlast_i;
        end else if (wready_i) begin
            wvalid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_grid_xni_w_steer.sv
// Bench for axi_grid_xni_w_steer: table-driven directed vectors, hand-written
// multi-cycle corner cases, and randomized traffic checked against a
// transaction-level model of bursts and their destinations.
module tb_axi_grid_xni_w_steer;

    localparam int GRID_ID_W = 4;
    localparam int ADDR_W    = 32;
    localparam int DID_LSB   = 28;
    localparam int AW_CHAN_W = 64;
    localparam int W_CHAN_W  = 72;
    localparam int DEPTH     = 4;
    localparam int NI_ID     = 5;
    localparam int CNT_W     = $clog2(DEPTH + 1);

    logic                 clk_i = 1'b0;
    logic                 rst_i;
    logic [ADDR_W-1:0]    awaddr_i;
    logic [AW_CHAN_W-1:0] awchan_i;
    logic                 awvalid_i;
    logic                 awready_o;
    logic [GRID_ID_W-1:0] awdid_o;
    logic [GRID_ID_W-1:0] awsid_o;
    logic [AW_CHAN_W-1:0] awchan_o;
    logic                 awvalid_o;
    logic                 awready_i;
    logic [W_CHAN_W-1:0]  wchan_i;
    logic                 wlast_i;
    logic                 wvalid_i;
    logic                 wready_o;
    logic [GRID_ID_W-1:0] wdid_o;
    logic [GRID_ID_W-1:0] wsid_o;
    logic [W_CHAN_W-1:0]  wchan_o;
    logic                 wlast_o;
    logic                 wvalid_o;
    logic                 wready_i;
    logic [CNT_W-1:0]     outstanding_o;

    int n_checks = 0;
    int n_errors = 0;

    axi_grid_xni_w_steer #(
        .GRID_ID_W(GRID_ID_W), .ADDR_W(ADDR_W), .DID_LSB(DID_LSB),
        .AW_CHAN_W(AW_CHAN_W), .W_CHAN_W(W_CHAN_W), .DEPTH(DEPTH), .NI_ID(NI_ID)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .awaddr_i(awaddr_i), .awchan_i(awchan_i), .awvalid_i(awvalid_i), .awready_o(awready_o),
        .awdid_o(awdid_o), .awsid_o(awsid_o), .awchan_o(awchan_o), .awvalid_o(awvalid_o),
        .awready_i(awready_i),
        .wchan_i(wchan_i), .wlast_i(wlast_i), .wvalid_i(wvalid_i), .wready_o(wready_o),
        .wdid_o(wdid_o), .wsid_o(wsid_o), .wchan_o(wchan_o), .wlast_o(wlast_o),
        .wvalid_o(wvalid_o), .wready_i(wready_i), .outstanding_o(outstanding_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [3:0] did;
        logic       awv;
        logic       wv;
        logic       wl;
        logic       exp_awrdy;
        logic       exp_wrdy;
        logic       exp_awv;
        logic [3:0] exp_awdid;
        logic       exp_wv;
        logic [3:0] exp_wdid;
        logic [2:0] exp_out;
    } vec_t;

    typedef struct {
        logic [GRID_ID_W-1:0] did;
        logic [AW_CHAN_W-1:0] chan;
    } aw_txn_t;

    typedef struct {
        logic [GRID_ID_W-1:0] did;
        logic [W_CHAN_W-1:0]  chan;
        logic                 last;
    } w_txn_t;

    vec_t    vecs [16];
    aw_txn_t aw_q [$];
    w_txn_t  w_q  [$];
    int      pend [$];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle_inputs();
        awaddr_i  = '0;
        awchan_i  = '0;
        awvalid_i = 1'b0;
        wchan_i   = '0;
        wlast_i   = 1'b0;
        wvalid_i  = 1'b0;
        awready_i = 1'b1;
        wready_i  = 1'b1;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic drive_aw(input logic v, input logic [3:0] did, input logic [AW_CHAN_W-1:0] chan);
        awvalid_i = v;
        awaddr_i  = {did, 28'h000_0010};
        awchan_i  = chan;
    endtask

    task automatic drive_w(input logic v, input logic last, input logic [W_CHAN_W-1:0] chan);
        wvalid_i = v;
        wlast_i  = last;
        wchan_i  = chan;
    endtask

    function automatic vec_t mk(input logic [3:0] did, input logic awv, input logic wv, input logic wl,
                                input logic awrdy, input logic wrdy, input logic oawv,
                                input logic [3:0] oawdid, input logic owv, input logic [3:0] owdid,
                                input logic [2:0] oout);
        vec_t v;
        v.did = did; v.awv = awv; v.wv = wv; v.wl = wl;
        v.exp_awrdy = awrdy; v.exp_wrdy = wrdy; v.exp_awv = oawv; v.exp_awdid = oawdid;
        v.exp_wv = owv; v.exp_wdid = owdid; v.exp_out = oout;
        return v;
    endfunction

    initial begin
        logic [95:0] r96;
        logic [63:0] r64;

        //            did awv wv wl | awrdy wrdy | awv awdid wv wdid out
        vecs[0]  = mk(3, 1, 1, 0,  1, 0,  1, 3, 0, 0, 1);  // AW to did 3; W before push is refused
        vecs[1]  = mk(0, 0, 1, 0,  1, 1,  0, 3, 1, 3, 1);
        vecs[2]  = mk(0, 0, 1, 0,  1, 1,  0, 3, 1, 3, 1);
        vecs[3]  = mk(0, 0, 1, 1,  1, 1,  0, 3, 1, 3, 0);  // wlast: drop on next cycle
        vecs[4]  = mk(0, 0, 0, 0,  1, 0,  0, 3, 0, 3, 0);
        vecs[5]  = mk(1, 1, 0, 0,  1, 0,  1, 1, 0, 3, 1);  // fill: dids 1..4
        vecs[6]  = mk(2, 1, 0, 0,  1, 1,  1, 2, 0, 3, 2);
        vecs[7]  = mk(3, 1, 0, 0,  1, 1,  1, 3, 0, 3, 3);
        vecs[8]  = mk(4, 1, 0, 0,  1, 1,  1, 4, 0, 3, 4);
        vecs[9]  = mk(5, 1, 0, 0,  0, 1,  0, 4, 0, 3, 4);  // full: fifth AW refused
        vecs[10] = mk(5, 1, 1, 1,  0, 1,  0, 4, 1, 1, 3);  // first pop
        vecs[11] = mk(5, 1, 1, 1,  1, 1,  1, 5, 1, 2, 3);  // fifth AW accepted with a pop
        vecs[12] = mk(0, 0, 1, 1,  1, 1,  0, 5, 1, 3, 2);
        vecs[13] = mk(0, 0, 1, 1,  1, 1,  0, 5, 1, 4, 1);
        vecs[14] = mk(0, 0, 1, 1,  1, 1,  0, 5, 1, 5, 0);
        vecs[15] = mk(0, 0, 0, 0,  1, 0,  0, 5, 0, 5, 0);

        // Reset then idle.
        do_reset();
        check("rst_awvalid", awvalid_o, 1'b0);
        check("rst_wvalid", wvalid_o, 1'b0);
        check("rst_outstanding", outstanding_o, 0);
        check("rst_awready", awready_o, 1'b1);
        check("rst_wready", wready_o, 1'b0);

        // Table-driven directed vectors, downstream always ready.
        for (int i = 0; i < 16; i++) begin
            drive_aw(vecs[i].awv, vecs[i].did, 64'(i));
            drive_w(vecs[i].wv, vecs[i].wl, 72'(i));
            #1;
            check($sformatf("v%0d_awready", i), awready_o, vecs[i].exp_awrdy);
            check($sformatf("v%0d_wready", i), wready_o, vecs[i].exp_wrdy);
            step();
            check($sformatf("v%0d_awvalid", i), awvalid_o, vecs[i].exp_awv);
            check($sformatf("v%0d_awdid", i), awdid_o, vecs[i].exp_awdid);
            check($sformatf("v%0d_wvalid", i), wvalid_o, vecs[i].exp_wv);
            check($sformatf("v%0d_wdid", i), wdid_o, vecs[i].exp_wdid);
            check($sformatf("v%0d_outstanding", i), outstanding_o, vecs[i].exp_out);
            if (vecs[i].exp_awv) check($sformatf("v%0d_awsid", i), awsid_o, NI_ID);
            if (vecs[i].exp_wv)  check($sformatf("v%0d_wsid", i), wsid_o, NI_ID);
        end
        idle_inputs();

        // Simultaneous push and pop at count 2.
        do_reset();
        drive_aw(1, 10, 64'hA); step();
        drive_aw(1, 11, 64'hB); step();
        check("pp_pre_out", outstanding_o, 2);
        drive_aw(1, 12, 64'hC);
        drive_w(1, 1, 72'h1);
        #1;
        check("pp_awready", awready_o, 1'b1);
        check("pp_wready", wready_o, 1'b1);
        step();
        check("pp_out", outstanding_o, 2);
        check("pp_wdid0", wdid_o, 10);
        drive_aw(0, 0, 0);
        drive_w(1, 1, 72'h2); step();
        check("pp_wdid1", wdid_o, 11);
        check("pp_out1", outstanding_o, 1);
        drive_w(1, 1, 72'h3); step();
        check("pp_wdid2", wdid_o, 12);
        check("pp_out2", outstanding_o, 0);
        idle_inputs();

        // Backpressure on both outputs for five cycles.
        do_reset();
        drive_aw(1, 6, 64'hAAAA_0000_1111_2222); step();
        drive_aw(1, 7, 64'h7);
        drive_w(1, 1, 72'hBB_0000_3333_4444_5555);
        awready_i = 1'b0;
        wready_i  = 1'b0;
        #1;
        check("bp_awready_b", awready_o, 1'b0);
        check("bp_wready_b", wready_o, 1'b1);
        step();
        drive_w(1, 1, 72'hC);
        for (int k = 0; k < 5; k++) begin
            #1;
            check("bp_awready", awready_o, 1'b0);
            check("bp_wready", wready_o, 1'b0);
            step();
            check("bp_awvalid", awvalid_o, 1'b1);
            check("bp_awchan", awchan_o, 64'hAAAA_0000_1111_2222);
            check("bp_awdid", awdid_o, 6);
            check("bp_wvalid", wvalid_o, 1'b1);
            check("bp_wchan", wchan_o, 72'hBB_0000_3333_4444_5555);
            check("bp_wdid", wdid_o, 6);
            check("bp_wlast", wlast_o, 1'b1);
        end
        idle_inputs();
        step();
        check("bp_rel_awvalid", awvalid_o, 1'b0);
        check("bp_rel_wvalid", wvalid_o, 1'b0);
        check("bp_rel_out", outstanding_o, 0);

        // Reset in the middle of a burst with three bursts pending.
        do_reset();
        drive_aw(1, 1, 64'h1); step();
        drive_aw(1, 2, 64'h2); step();
        drive_aw(1, 3, 64'h3); step();
        drive_aw(0, 0, 0);
        drive_w(1, 0, 72'h10); step();
        drive_w(1, 0, 72'h11); step();
        check("mr_pre_out", outstanding_o, 3);
        check("mr_pre_wvalid", wvalid_o, 1'b1);
        drive_aw(1, 4, 64'h4);
        drive_w(1, 1, 72'h12);
        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        idle_inputs();
        check("mr_awvalid", awvalid_o, 1'b0);
        check("mr_wvalid", wvalid_o, 1'b0);
        check("mr_out", outstanding_o, 0);
        check("mr_wdid", wdid_o, 0);
        check("mr_awdid", awdid_o, 0);
        drive_aw(1, 9, 64'h9); step();
        check("mr_new_awdid", awdid_o, 9);
        drive_aw(0, 0, 0);
        drive_w(1, 1, 72'h99); step();
        check("mr_new_wdid", wdid_o, 9);
        check("mr_new_wvalid", wvalid_o, 1'b1);
        check("mr_new_out", outstanding_o, 0);
        idle_inputs();

        // Randomized traffic against a burst-level model.
        do_reset();
        aw_q.delete();
        w_q.delete();
        pend.delete();
        for (int c = 0; c < 3000; c++) begin
            logic exp_awrdy;
            logic exp_wrdy;
            aw_txn_t at;
            w_txn_t  wt;
            awvalid_i = ($urandom_range(0, 9) < 7);
            awaddr_i  = $urandom();
            r64       = {$urandom(), $urandom()};
            awchan_i  = r64;
            wvalid_i  = ($urandom_range(0, 9) < 7);
            wlast_i   = ($urandom_range(0, 2) == 0);
            r96       = {$urandom(), $urandom(), $urandom()};
            wchan_i   = r96[W_CHAN_W-1:0];
            awready_i = ($urandom_range(0, 9) < 7);
            wready_i  = ($urandom_range(0, 9) < 6);
            #1;
            exp_awrdy = (aw_q.size() == 0 || awready_i) && (pend.size() != DEPTH);
            exp_wrdy  = (w_q.size() == 0 || wready_i) && (pend.size() != 0);
            check("r_awready", awready_o, exp_awrdy);
            check("r_wready", wready_o, exp_wrdy);
            check("r_outstanding", outstanding_o, pend.size());
            check("r_awvalid", awvalid_o, aw_q.size() != 0);
            check("r_wvalid", wvalid_o, w_q.size() != 0);
            if (aw_q.size() != 0) begin
                check("r_awdid", awdid_o, aw_q[0].did);
                check("r_awsid", awsid_o, NI_ID);
                check("r_awchan", awchan_o, aw_q[0].chan);
            end
            if (w_q.size() != 0) begin
                check("r_wdid", wdid_o, w_q[0].did);
                check("r_wsid", wsid_o, NI_ID);
                check("r_wchan", wchan_o, w_q[0].chan);
                check("r_wlast", wlast_o, w_q[0].last);
            end
            // Model update for this clock edge.
            if (aw_q.size() != 0 && awready_i) void'(aw_q.pop_front());
            if (w_q.size() != 0 && wready_i) void'(w_q.pop_front());
            if (wvalid_i && exp_wrdy) begin
                wt.did  = GRID_ID_W'(pend[0]);
                wt.chan = wchan_i;
                wt.last = wlast_i;
                w_q.push_back(wt);
                if (wlast_i) void'(pend.pop_front());
            end
            if (awvalid_i && exp_awrdy) begin
                at.did  = awaddr_i[DID_LSB +: GRID_ID_W];
                at.chan = awchan_i;
                aw_q.push_back(at);
                pend.push_back(int'(at.did));
            end
            step();
        end
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
